// File: rtl/clock_monitor.sv
// clock_monitor: measures period and high time of an asynchronous clock in system cycles and flags stalls.
// High-time measurement is built only when CLOCK_MONITOR_DUTY_EN is defined; otherwise o_high is tied to 0.
module clock_monitor #(
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 1000
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_enable,
  input  logic             i_signal,
  output logic [WIDTH-1:0] o_period,
  output logic [WIDTH-1:0] o_high,
  output logic             o_valid,
  output logic             o_running,
  output logic             o_stalled
);

  localparam logic [WIDTH-1:0] CNT_MAX   = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] CNT_ONE   = WIDTH'(1);
  localparam logic [WIDTH-1:0] TIMEOUT_W = WIDTH'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    MEASURE,
    STALLED
  } state_t;

  logic             sync1_q;
  logic             sync2_q;
  logic             hist_q;
  logic             rise;
  logic             timed_out;

  state_t           state_q;
  logic [WIDTH-1:0] period_cnt_q;
  logic [WIDTH-1:0] period_cnt_d;
  logic [WIDTH-1:0] period_q;
  logic             valid_q;
  logic             running_q;
  logic             stalled_q;

  // Two-flop synchroniser followed by a history flop for edge detection.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      hist_q  <= 1'b0;
    end else begin
      sync1_q <= i_signal;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
    end
  end

  assign rise         = sync2_q & ~hist_q;
  assign period_cnt_d = (period_cnt_q == CNT_MAX) ? period_cnt_q : period_cnt_q + CNT_ONE;
  assign timed_out    = (period_cnt_q >= TIMEOUT_W);

  // The counter holds 1 in the cycle after a rise, so at the next rise it equals the edge distance.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q      <= IDLE;
      period_cnt_q <= '0;
      period_q     <= '0;
      valid_q      <= 1'b0;
      running_q    <= 1'b0;
      stalled_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (!i_enable) begin
        state_q      <= IDLE;
        period_cnt_q <= '0;
        running_q    <= 1'b0;
        stalled_q    <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            state_q      <= ARM;
            period_cnt_q <= CNT_ONE;
          end
          ARM: begin
            if (rise) begin
              state_q      <= MEASURE;
              period_cnt_q <= CNT_ONE;
            end else if (timed_out) begin
              state_q      <= STALLED;
              stalled_q    <= 1'b1;
              running_q    <= 1'b0;
              period_cnt_q <= period_cnt_d;
            end else begin
              period_cnt_q <= period_cnt_d;
            end
          end
          MEASURE: begin
            if (rise) begin
              valid_q      <= 1'b1;
              period_q     <= period_cnt_q;
              running_q    <= 1'b1;
              period_cnt_q <= CNT_ONE;
            end else if (timed_out) begin
              state_q      <= STALLED;
              stalled_q    <= 1'b1;
              running_q    <= 1'b0;
              period_cnt_q <= period_cnt_d;
            end else begin
              period_cnt_q <= period_cnt_d;
            end
          end
          STALLED: begin
            if (rise) begin
              state_q      <= MEASURE;
              stalled_q    <= 1'b0;
              period_cnt_q <= CNT_ONE;
            end else begin
              period_cnt_q <= period_cnt_d;
            end
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign o_period  = period_q;
  assign o_valid   = valid_q;
  assign o_running = running_q;
  assign o_stalled = stalled_q;

`ifdef CLOCK_MONITOR_DUTY_EN
  logic             fall;
  logic             high_phase_q;
  logic [WIDTH-1:0] high_cnt_q;
  logic [WIDTH-1:0] high_cnt_d;
  logic [WIDTH-1:0] high_q;

  assign fall       = ~sync2_q & hist_q;
  assign high_cnt_d = (high_cnt_q == CNT_MAX) ? high_cnt_q : high_cnt_q + CNT_ONE;

  // High count freezes at the first fall and is reported alongside the period at the next rise.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      high_phase_q <= 1'b0;
      high_cnt_q   <= '0;
      high_q       <= '0;
    end else if (!i_enable || state_q == IDLE) begin
      high_phase_q <= 1'b0;
      high_cnt_q   <= '0;
    end else if (rise) begin
      if (state_q == MEASURE) begin
        high_q <= high_cnt_q;
      end
      high_phase_q <= 1'b1;
      high_cnt_q   <= CNT_ONE;
    end else if (high_phase_q) begin
      if (fall) begin
        high_phase_q <= 1'b0;
      end else begin
        high_cnt_q <= high_cnt_d;
      end
    end
  end

  assign o_high = high_q;
`else
  assign o_high = '0;
`endif

endmodule

// File: tb/tb_clock_monitor.sv
// Bench for clock_monitor: two instances (16-bit/TIMEOUT 64 and 4-bit/TIMEOUT 15) share stimulus and are
// compared every cycle against a timestamp-based reference model of the measurement rules.
module tb_clock_monitor;

  localparam int M_OFF   = 0;
  localparam int M_ARM   = 1;
  localparam int M_MEAS  = 2;
  localparam int M_STALL = 3;
`ifdef CLOCK_MONITOR_DUTY_EN
  localparam bit DUTY = 1'b1;
`else
  localparam bit DUTY = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;
  logic        sig = 1'b0;

  logic [15:0] per_m, high_m;
  logic        valid_m, run_m, stall_m;
  logic [3:0]  per_s, high_s;
  logic        valid_s, run_s, stall_s;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic en_cur  = 1'b0;
  logic en_last = 1'b0;
  logic hist [8];

  int to_c  [2] = '{64, 15};
  int max_c [2] = '{65535, 15};
  int mode  [2] = '{0, 0};
  int ref_c [2] = '{0, 0};
  int fall_c[2] = '{0, 0};
  bit fall_seen[2];
  int e_per [2] = '{0, 0};
  int e_high[2] = '{0, 0};
  bit e_valid[2];
  bit e_run  [2];
  bit e_stall[2];

  always #5 clk = ~clk;

  clock_monitor #(.WIDTH(16), .TIMEOUT(64)) dut_main (
    .i_clock(clk), .i_reset(rst), .i_enable(en), .i_signal(sig),
    .o_period(per_m), .o_high(high_m), .o_valid(valid_m), .o_running(run_m), .o_stalled(stall_m)
  );

  clock_monitor #(.WIDTH(4), .TIMEOUT(15)) dut_sat (
    .i_clock(clk), .i_reset(rst), .i_enable(en), .i_signal(sig),
    .o_period(per_s), .o_high(high_s), .o_valid(valid_s), .o_running(run_s), .o_stalled(stall_s)
  );

  function automatic int sat(input int v, input int m);
    return (v > m) ? m : v;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d at step %0d", tag, obs, exp, cyc);
    end
  endtask

  // An edge driven at step N reaches the outputs at step N+3; enable driven at step N acts at step N+1.
  task automatic model_step(input int k);
    int t3, t4;
    logic [2:0] i3, i4;
    logic r, f;
    t3 = cyc - 3;
    t4 = cyc - 4;
    i3 = t3[2:0];
    i4 = t4[2:0];
    r = hist[i3] & ~hist[i4];
    f = ~hist[i3] & hist[i4];
    e_valid[k] = 1'b0;
    if (rst) begin
      mode[k] = M_OFF; e_per[k] = 0; e_high[k] = 0; e_run[k] = 1'b0; e_stall[k] = 1'b0;
    end else if (!en_last) begin
      mode[k] = M_OFF; e_run[k] = 1'b0; e_stall[k] = 1'b0;
    end else if (mode[k] == M_OFF) begin
      mode[k] = M_ARM; ref_c[k] = cyc; fall_seen[k] = 1'b0;
    end else if (r) begin
      if (mode[k] == M_MEAS) begin
        e_valid[k] = 1'b1;
        e_per[k]   = sat(cyc - ref_c[k], max_c[k]);
        e_high[k]  = DUTY ? sat(fall_seen[k] ? fall_c[k] - ref_c[k] : cyc - ref_c[k], max_c[k]) : 0;
        e_run[k]   = 1'b1;
      end
      mode[k] = M_MEAS; ref_c[k] = cyc; fall_seen[k] = 1'b0; e_stall[k] = 1'b0;
    end else begin
      if (f && !fall_seen[k]) begin
        fall_seen[k] = 1'b1;
        fall_c[k]    = cyc;
      end
      if (mode[k] != M_STALL && (cyc - ref_c[k]) >= to_c[k]) begin
        mode[k] = M_STALL; e_stall[k] = 1'b1; e_run[k] = 1'b0;
      end
    end
  endtask

  task automatic check_all();
    check("main_valid",   32'(valid_m), 32'(e_valid[0]));
    check("main_period",  32'(per_m),   32'(e_per[0]));
    check("main_high",    32'(high_m),  32'(e_high[0]));
    check("main_running", 32'(run_m),   32'(e_run[0]));
    check("main_stalled", 32'(stall_m), 32'(e_stall[0]));
    check("sat_valid",    32'(valid_s), 32'(e_valid[1]));
    check("sat_period",   32'(per_s),   32'(e_per[1]));
    check("sat_high",     32'(high_s),  32'(e_high[1]));
    check("sat_running",  32'(run_s),   32'(e_run[1]));
    check("sat_stalled",  32'(stall_s), 32'(e_stall[1]));
  endtask

  task automatic step(input logic s, input logic e);
    logic [2:0] idx;
    @(negedge clk);
    cyc++;
    model_step(0);
    model_step(1);
    check_all();
    sig = s;
    en  = e;
    idx = cyc[2:0];
    hist[idx] = rst ? 1'b0 : s;
    en_last   = e;
  endtask

  task automatic run_clock(input int p, input int h, input int n);
    for (int i = 0; i < n; i++)
      for (int j = 0; j < p; j++)
        step(j < h, en_cur);
  endtask

  initial begin
    int p, h;
    for (int i = 0; i < 8; i++) hist[i] = 1'b0;

    // Reset with enable low, then release.
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0);
    rst = 1'b0;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);

    en_cur = 1'b1;
    run_clock(10, 5, 8);
    run_clock(10, 3, 6);

    for (int r = 0; r < 4; r++) begin
      p = $urandom_range(14, 4);
      h = $urandom_range(p - 2, 2);
      run_clock(p, h, $urandom_range(6, 3));
    end

    // Stall and recovery.
    for (int i = 0; i < 90; i++) step(1'b0, 1'b1);
    run_clock(10, 5, 5);

    // Period 12 on the 4-bit instance, then stop.
    run_clock(12, 6, 5);
    for (int i = 0; i < 30; i++) step(1'b0, 1'b1);

    // Edge exactly at the timeout boundary, then just beyond it.
    run_clock(64, 30, 4);
    run_clock(65, 30, 3);

    // Enable dropped mid-measurement for 20 cycles.
    run_clock(10, 5, 3);
    for (int k = 0; k < 40; k++) step((k % 10) < 5, !(k >= 13 && k < 33));
    run_clock(10, 5, 4);

    // Asynchronous reset in the middle of a high phase.
    run_clock(10, 5, 3);
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_period", 32'(per_m),   32'd0);
    check("async_rst_high",   32'(high_m),  32'd0);
    check("async_rst_valid",  32'(valid_m), 32'd0);
    check("async_rst_run",    32'(run_m),   32'd0);
    check("async_rst_stall",  32'(stall_m), 32'd0);
    check("async_rst_sat_p",  32'(per_s),   32'd0);
    check("async_rst_sat_r",  32'(run_s),   32'd0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1);
    rst = 1'b0;
    run_clock(10, 5, 6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
